// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter slice.
package wb_write_arbiter_pkg;

   localparam int  REG_BUS_W     = 32;
   localparam int  REG_ADDR_W    = 5;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic RST_ENABLE    = 1'b1;
   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
   localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_FIFO = 2'd2
   } wb_src_e;

   // The in-order pipe always owns the port; the FIFO only fills holes.
   function automatic wb_src_e pick_src(input logic pipe_wr, input logic fifo_nonempty);
      if (pipe_wr)
         return SRC_PIPE;
      else if (fifo_nonempty)
         return SRC_FIFO;
      else
         return SRC_NONE;
   endfunction

endpackage

// File: rtl/wb_write_arbiter_ll_fifo.sv
// Small circular FIFO holding long-latency {addr,data} results awaiting the write port.
module wb_ll_fifo
   import wb_write_arbiter_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [ADDR_W-1:0]         push_addr,
   input  logic [DATA_W-1:0]         push_data,
   input  logic                      pop,
   output logic [$clog2(DEPTH):0]    count,
   output logic [ADDR_W-1:0]         head_addr,
   output logic [DATA_W-1:0]         head_data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/wb_write_arbiter.sv
// Write-back stage: merges MEM results and buffered long-latency results onto the
// single regfile write port, and tracks registers with outstanding long-latency writes.
module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int REG_NUM = 32,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_wreg_i,
   input  logic [ADDR_W-1:0] mem_waddr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic [DATA_W-1:0] mem_inst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              ll_issue_i,
   input  logic [ADDR_W-1:0] ll_issue_addr_i,
   input  logic              ll_valid_i,
   output logic              ll_ready_o,
   input  logic [ADDR_W-1:0] ll_waddr_i,
   input  logic [DATA_W-1:0] ll_wdata_i,
   input  logic [ADDR_W-1:0] rd_addr1_i,
   input  logic [ADDR_W-1:0] rd_addr2_i,
   output logic              busy1_o,
   output logic              busy2_o,
   output logic              stall_req_o,
   output logic              wb_wreg_o,
   output logic [ADDR_W-1:0] wb_waddr_o,
   output logic [DATA_W-1:0] wb_wdata_o,
   output logic [DATA_W-1:0] wb_inst_o
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [CNT_W-1:0]   count;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;
   logic               pipe_wr_p0;
   logic               pop_p0;
   logic               push_p0;
   wb_src_e            src_p0;
   logic [REG_NUM-1:0] sb;
   logic [REG_NUM-1:0] sb_next;

   logic               vld_p1;
   logic [ADDR_W-1:0]  waddr_p1;
   logic [DATA_W-1:0]  wdata_p1;
   logic [DATA_W-1:0]  inst_p1;

   assign pipe_wr_p0  = mem_wreg_i & (mem_waddr_i != '0) & ~stall_i & ~flush_i;
   assign pop_p0      = ~pipe_wr_p0 & (count != '0);
   assign ll_ready_o  = (count < FULL_CNT);
   assign stall_req_o = (count == FULL_CNT);
   // Results aimed at $0 are acknowledged but never queued.
   assign push_p0     = ll_valid_i & ll_ready_o & (ll_waddr_i != '0);
   assign src_p0      = pick_src(pipe_wr_p0, count != '0);

   wb_ll_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ll_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_p0),
      .push_addr (ll_waddr_i),
      .push_data (ll_wdata_i),
      .pop       (pop_p0),
      .count     (count),
      .head_addr (head_addr),
      .head_data (head_data)
   );

   // Clear is applied before set so a same-cycle re-issue keeps the bit busy.
   always_comb begin
      sb_next = sb;
      if (pop_p0)
         sb_next[head_addr] = 1'b0;
      if (ll_issue_i && (ll_issue_addr_i != '0))
         sb_next[ll_issue_addr_i] = 1'b1;
   end

   assign busy1_o = sb[rd_addr1_i] & (rd_addr1_i != '0);
   assign busy2_o = sb[rd_addr2_i] & (rd_addr2_i != '0);

   // ---- p0 -> p1: write-port registers ----
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         sb       <= '0;
         vld_p1   <= WRITE_DISABLE;
         waddr_p1 <= '0;
         wdata_p1 <= '0;
         inst_p1  <= '0;
      end else begin
         sb <= sb_next;
         case (src_p0)
            SRC_PIPE: begin
               vld_p1   <= WRITE_ENABLE;
               waddr_p1 <= mem_waddr_i;
               wdata_p1 <= mem_wdata_i;
               inst_p1  <= mem_inst_i;
            end
            SRC_FIFO: begin
               vld_p1   <= WRITE_ENABLE;
               waddr_p1 <= head_addr;
               wdata_p1 <= head_data;
               inst_p1  <= '0;
            end
            default: begin
               vld_p1   <= WRITE_DISABLE;
               waddr_p1 <= '0;
               wdata_p1 <= '0;
               inst_p1  <= '0;
            end
         endcase
      end
   end

   assign wb_wreg_o  = vld_p1;
   assign wb_waddr_o = waddr_p1;
   assign wb_wdata_o = wdata_p1;
   assign wb_inst_o  = inst_p1;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_write_arbiter;

   localparam int DEPTH  = 2;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_wreg_i;
   logic [ADDR_W-1:0] mem_waddr_i;
   logic [DATA_W-1:0] mem_wdata_i;
   logic [DATA_W-1:0] mem_inst_i;
   logic              stall_i;
   logic              flush_i;
   logic              ll_issue_i;
   logic [ADDR_W-1:0] ll_issue_addr_i;
   logic              ll_valid_i;
   logic              ll_ready_o;
   logic [ADDR_W-1:0] ll_waddr_i;
   logic [DATA_W-1:0] ll_wdata_i;
   logic [ADDR_W-1:0] rd_addr1_i;
   logic [ADDR_W-1:0] rd_addr2_i;
   logic              busy1_o;
   logic              busy2_o;
   logic              stall_req_o;
   logic              wb_wreg_o;
   logic [ADDR_W-1:0] wb_waddr_o;
   logic [DATA_W-1:0] wb_wdata_o;
   logic [DATA_W-1:0] wb_inst_o;

   always #5 clk = ~clk;

   wb_write_arbiter #(.DEPTH(DEPTH), .REG_NUM(32), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .mem_wreg_i(mem_wreg_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
      .mem_inst_i(mem_inst_i), .stall_i(stall_i), .flush_i(flush_i),
      .ll_issue_i(ll_issue_i), .ll_issue_addr_i(ll_issue_addr_i),
      .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o),
      .ll_waddr_i(ll_waddr_i), .ll_wdata_i(ll_wdata_i),
      .rd_addr1_i(rd_addr1_i), .rd_addr2_i(rd_addr2_i),
      .busy1_o(busy1_o), .busy2_o(busy2_o), .stall_req_o(stall_req_o),
      .wb_wreg_o(wb_wreg_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
      .wb_inst_o(wb_inst_o)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending results as a queue, pending registers as a bit array.
   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t        q[$];
   logic [31:0] pend;
   logic        e_wreg;
   logic [ADDR_W-1:0] e_waddr;
   logic [DATA_W-1:0] e_wdata;
   logic [DATA_W-1:0] e_inst;

   task automatic idle_inputs();
      rst = 0; mem_wreg_i = 0; mem_waddr_i = 0; mem_wdata_i = 0; mem_inst_i = 0;
      stall_i = 0; flush_i = 0; ll_issue_i = 0; ll_issue_addr_i = 0;
      ll_valid_i = 0; ll_waddr_i = 0; ll_wdata_i = 0;
   endtask

   // One clock: check combinational outputs, advance model, check write port.
   task automatic cycle();
      bit   pipe_wr;
      bit   ready;
      ent_t h;
      @(negedge clk);
      ready = (q.size() < DEPTH);
      check_val("ll_ready", ll_ready_o, ready);
      check_val("stall_req", stall_req_o, q.size() == DEPTH);
      check_val("busy1", busy1_o, pend[rd_addr1_i] && rd_addr1_i != 0);
      check_val("busy2", busy2_o, pend[rd_addr2_i] && rd_addr2_i != 0);
      pipe_wr = mem_wreg_i && mem_waddr_i != 0 && !stall_i && !flush_i;
      if (rst) begin
         q.delete();
         pend = '0;
         {e_wreg, e_waddr, e_wdata, e_inst} = '0;
      end else begin
         {e_wreg, e_waddr, e_wdata, e_inst} = '0;
         if (pipe_wr) begin
            e_wreg = 1; e_waddr = mem_waddr_i; e_wdata = mem_wdata_i; e_inst = mem_inst_i;
         end else if (q.size() > 0) begin
            h = q.pop_front();
            e_wreg = 1; e_waddr = h.a; e_wdata = h.d;
            pend[h.a] = 1'b0;
         end
         if (ll_valid_i && ready && ll_waddr_i != 0)
            q.push_back('{a: ll_waddr_i, d: ll_wdata_i});
         if (ll_issue_i && ll_issue_addr_i != 0)
            pend[ll_issue_addr_i] = 1'b1;
      end
      @(posedge clk);
      #1;
      check_val("wb_wreg", wb_wreg_o, e_wreg);
      check_val("wb_waddr", wb_waddr_o, e_waddr);
      check_val("wb_wdata", wb_wdata_o, e_wdata);
      check_val("wb_inst", wb_inst_o, e_inst);
   endtask

   task automatic mem_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      mem_wreg_i = 1; mem_waddr_i = a; mem_wdata_i = d; mem_inst_i = d ^ 32'hA5A5_0000;
   endtask

   initial begin
      pend = '0;
      idle_inputs();
      rd_addr1_i = 0; rd_addr2_i = 0;

      // Reset held with a pending MEM write.
      rst = 1; mem_write(5'd3, 32'h1234);
      repeat (3) begin
         cycle();
         check_val("rst_wreg", wb_wreg_o, 0);
      end
      idle_inputs();

      // Back-to-back MEM writes to $1.
      mem_write(5'd1, 32'h11); cycle();
      check_val("mem_first", wb_wdata_o, 32'h11);
      mem_write(5'd1, 32'h22); cycle();
      check_val("mem_second", wb_wdata_o, 32'h22);
      idle_inputs();

      // Long-latency $5: busy until the result reaches the port.
      rd_addr1_i = 5;
      ll_issue_i = 1; ll_issue_addr_i = 5; cycle();
      idle_inputs();
      check_val("busy5_set", busy1_o, 1);
      repeat (3) cycle();
      ll_valid_i = 1; ll_waddr_i = 5; ll_wdata_i = 32'hABCD; cycle();
      idle_inputs();
      check_val("busy5_held", busy1_o, 1);
      cycle();
      check_val("ll5_data", wb_wdata_o, 32'hABCD);
      check_val("busy5_clear", busy1_o, 0);

      // FIFO fills under continuous MEM traffic, then drains under stall.
      ll_issue_i = 1; ll_issue_addr_i = 9; mem_write(5'd3, 32'h300); cycle();
      ll_issue_addr_i = 10; mem_write(5'd3, 32'h301);
      ll_valid_i = 1; ll_waddr_i = 9; ll_wdata_i = 32'h900; cycle();
      ll_issue_i = 0; mem_write(5'd3, 32'h302);
      ll_waddr_i = 10; ll_wdata_i = 32'h1000; cycle();
      ll_valid_i = 0; ll_waddr_i = 11;
      check_val("full_stall_req", stall_req_o, 1);
      check_val("full_not_ready", ll_ready_o, 0);
      mem_write(5'd3, 32'h303); stall_i = 1; cycle();
      check_val("drain0", wb_waddr_o, 9);
      cycle();
      check_val("drain1", wb_wdata_o, 32'h1000);
      stall_i = 0; cycle();
      check_val("mem_resume", wb_wdata_o, 32'h303);
      idle_inputs();

      // Pop of $7 coinciding with a fresh issue of $7: stays busy.
      rd_addr1_i = 7; rd_addr2_i = 0;
      ll_issue_i = 1; ll_issue_addr_i = 7; cycle();
      idle_inputs();
      ll_valid_i = 1; ll_waddr_i = 7; ll_wdata_i = 32'h77; cycle();
      idle_inputs();
      ll_issue_i = 1; ll_issue_addr_i = 7; cycle();
      idle_inputs();
      check_val("sb7_set_wins", busy1_o, 1);
      rd_addr1_i = 0; cycle();
      check_val("busy_r0", busy1_o, 0);

      // Reset while FIFO holds two entries.
      mem_write(5'd4, 32'h40); ll_valid_i = 1; ll_waddr_i = 12; ll_wdata_i = 32'hC0; cycle();
      ll_waddr_i = 13; ll_wdata_i = 32'hD0; cycle();
      idle_inputs();
      check_val("pre_rst_full", stall_req_o, 1);
      rst = 1; cycle();
      rst = 0; rd_addr1_i = 7;
      repeat (3) begin
         cycle();
         check_val("post_rst_quiet", wb_wreg_o, 0);
      end

      // Random traffic on a small register range.
      for (int i = 0; i < 1500; i++) begin
         rst             = ($urandom_range(0, 199) == 0);
         mem_wreg_i      = ($urandom_range(0, 99) < 55);
         mem_waddr_i     = ADDR_W'($urandom_range(0, 7));
         mem_wdata_i     = $urandom;
         mem_inst_i      = $urandom;
         stall_i         = (q.size() == DEPTH) || ($urandom_range(0, 9) == 0);
         flush_i         = ($urandom_range(0, 9) == 0);
         ll_issue_i      = ($urandom_range(0, 3) == 0);
         ll_issue_addr_i = ADDR_W'($urandom_range(0, 7));
         ll_valid_i      = ($urandom_range(0, 2) == 0);
         ll_waddr_i      = ADDR_W'($urandom_range(0, 7));
         ll_wdata_i      = $urandom;
         rd_addr1_i      = ADDR_W'($urandom_range(0, 7));
         rd_addr2_i      = ADDR_W'($urandom_range(0, 7));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
